// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared constants for the UART transmitter: FSM state
//                encoding and parity-type selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Transmit FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    // Parity type selectors (Parity_type input)
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sync_fifo
//  Description : Single-clock FIFO with occupancy count, full and empty flags.
//                Writes while full and reads while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic [DATA_WIDTH-1:0]         i_wr_data,
    input  logic                          i_rd_en,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    // A full FIFO refuses the write even if a read happens on the same edge
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;
    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_gen
//  Description : Parametrised UART transmitter with input FIFO, optional
//                even/odd parity, one or two stop bits and runtime prescale.
//                Frame settings are latched when a word leaves the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  Data_valid,
    output logic                  Ready,
    input  logic                  Parity_EN,
    input  logic                  Parity_type,
    input  logic                  Stop2,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  Tx_out,
    output logic                  Busy,
    output logic                  Overflow
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]            r_state;
    logic [PRESCALE_W-1:0] r_cnt;
    logic [PRESCALE_W-1:0] r_pres;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_head;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_last;
    logic                  w_frame_end;
    logic [PRESCALE_W-1:0] w_pres;
    logic [PRESCALE_W-1:0] w_reload;

    uart_tx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (Reset),
        .i_wr_en   (Data_valid),
        .i_wr_data (Data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Ready comes from the registered occupancy, so it is glitch-free
    assign Ready    = (w_count != CNT_W'(FIFO_DEPTH)) && !w_full;
    assign Tx_out   = r_tx;
    assign Busy     = r_busy;
    assign Overflow = r_overflow;

    // Prescale of zero behaves as one cycle per bit
    assign w_pres   = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
    assign w_reload = r_pres - PRESCALE_W'(1);
    assign w_last   = (r_cnt == '0);

    // Final stop bit ends on this cycle; a queued word then starts with no gap
    assign w_frame_end = w_last &&
                         (((r_state == ST_STOP1) && !r_stop2) || (r_state == ST_STOP2));
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

    // Rejected writes produce a one-cycle pulse; the data is dropped
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= Data_valid && !Ready;
        end
    end

    // Frame sequencer: each state holds the line for r_pres cycles
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_pres    <= PRESCALE_W'(1);
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else if (w_pop) begin
            // Start a new frame and latch its configuration
            r_shift   <= w_head;
            r_par_en  <= Parity_EN;
            r_stop2   <= Stop2;
            r_par_bit <= (^w_head) ^ (Parity_type == PAR_ODD);
            r_pres    <= w_pres;
            r_cnt     <= w_pres - PRESCALE_W'(1);
            r_bit     <= '0;
            r_state   <= ST_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            if ((r_state != ST_IDLE) && !w_last) begin
                r_cnt <= r_cnt - PRESCALE_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                ST_START: begin
                    if (w_last) begin
                        r_state <= ST_DATA;
                        r_cnt   <= w_reload;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_last) begin
                        r_cnt <= w_reload;
                        if (r_bit == BIT_W'(DATA_WIDTH - 1)) begin
                            if (r_par_en) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_par_bit;
                            end else begin
                                r_state <= ST_STOP1;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_last) begin
                        r_state <= ST_STOP1;
                        r_cnt   <= w_reload;
                        r_tx    <= 1'b1;
                    end
                end
                ST_STOP1: begin
                    if (w_last) begin
                        r_cnt <= w_reload;
                        r_tx  <= 1'b1;
                        if (r_stop2) begin
                            r_state <= ST_STOP2;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_STOP2: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
